sipo_word_assembler: RTL and testbench
======================================

Name: sipo_word_assembler

Overview:
Upstream serial-to-parallel stage. Collects a serial bit stream into WIDTH-bit words and presents each completed word on a parallel bus with a valid/ready handshake, for capture by the downstream parallel-in/parallel-out register stage. A frame-sync input realigns word boundaries. A sticky flag reports words lost to backpressure.

Parameters:
WIDTH, 4, word width in bits; legal range 2..32.
MSB_FIRST, 1, 1 = first received bit lands in dout[WIDTH-1]; 0 = first received bit lands in dout[0].
CW, $clog2(WIDTH), bit-counter width; derived, must not be overridden.

Ports:
clk  input  1  clock; all logic on the rising edge.
rst  input  1  asynchronous, active-high reset.
sin  input  1  serial data bit.
sin_valid  input  1  sin is sampled on a rising edge only when this is 1.
start  input  1  frame sync; discards any partial word and restarts bit count.
dout  output  WIDTH  assembled word (holding register).
dout_valid  output  1  dout holds an unconsumed word.
dout_ready  input  1  downstream accepts dout when dout_valid=1 at a rising edge.
overrun  output  1  sticky; a completed word was dropped.
clr_overrun  input  1  synchronous clear of overrun.
bit_cnt  output  CW  number of bits held in the partial word (0..WIDTH-1).

Behaviour:
- Reset (async, immediate): shift register=0, bit_cnt=0, dout=0, dout_valid=0, overrun=0.
- Shift: when sin_valid=1, the bit enters the internal shift register. MSB_FIRST=1 shifts left with sin entering at bit 0. MSB_FIRST=0 shifts right with sin entering at bit WIDTH-1. bit_cnt increments.
- Completion: the edge that samples the WIDTH-th bit (bit_cnt=WIDTH-1 with sin_valid=1) is the completion edge. On that edge bit_cnt wraps to 0 and the full word, including the current bit, is offered to the holding register.
- Latency: dout and dout_valid update on the completion edge itself. They are visible in the following cycle, one cycle after the last bit is presented.
- Handshake: a transfer occurs at an edge where dout_valid=1 and dout_ready=1. While dout_valid=1 and dout_ready=0, dout is held stable.
- Holding-register update priority at each edge:
  - Completion with the holding register empty or being consumed on the same edge: load the new word; dout_valid=1. Simultaneous consume and complete leaves dout_valid high with the new word.
  - Completion with the holding register full and not consumed: drop the new word, keep dout, set overrun=1.
  - Consume without completion: dout_valid=0; dout keeps its last value.
- start=1:
  - Discards the partial word.
  - If sin_valid=1, sin becomes bit 1 of a new word and bit_cnt=1. With WIDTH=1 not legal, no completion can occur on that edge.
  - If sin_valid=0, bit_cnt=0.
  - Does not affect dout, dout_valid or overrun.
- sin_valid=0 and start=0: shift register and bit_cnt hold.
- overrun: set by a dropped word; cleared by clr_overrun=1. Set has priority over clear on the same edge. Cleared only by reset or clr_overrun.
- Reset asserted mid-word or with dout_valid=1: all state clears immediately, and any pending word is lost without setting overrun.
- dout_ready is ignored while dout_valid=0.

Test Plan:
- WIDTH=4, MSB_FIRST=1, dout_ready=1; sin=1,0,1,1 on 4 consecutive valid cycles -> dout=4'b1011 and dout_valid=1 for exactly one cycle after the 4th edge; bit_cnt sequence 1,2,3,0.
- MSB_FIRST=0, same bits -> dout=4'b1101.
- dout_ready=0; send 1011 then 0110 -> dout stays 1011, overrun=1 after the 8th bit. dout_ready=1 -> dout_valid drops. clr_overrun=1 -> overrun=0.
- dout_ready=0 until the completion edge of the 2nd word (0110), then dout_ready=1 on that same edge -> dout=0110, dout_valid stays 1, overrun stays 0.
- Send 1,0 then start=1 with sin_valid=1 and sin=1, then 1,0,0 -> dout=4'b1100; the partial "10" is discarded; bit_cnt=1 after the start edge.
- Assert rst asynchronously after 2 bits, and again with dout_valid=1 -> bit_cnt, dout, dout_valid and overrun go to 0 before the next edge; the next 4 bits 0,1,1,1 -> dout=4'b0111.

Source files
------------

// File: rtl/sipo_word_assembler.sv
// Serial-in, parallel-out word assembler with a single-entry holding register,
// valid/ready output handshake, frame-sync realignment and sticky overrun flag.
module sipo_word_assembler #(
  parameter int WIDTH          = 4,
  parameter int unsigned MSB_FIRST = 1,
  localparam int CW            = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             clr_overrun,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] fresh;
  logic             complete;
  logic             consume;
  logic             drop;

  // shifted: current bit appended to the partial word; fresh: first bit of a
  // word started by frame sync, with the discarded partial word zeroed out.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shifted = {sr_q[WIDTH-2:0], sin};
      assign fresh   = {{(WIDTH-1){1'b0}}, sin};
    end else begin : g_lsb_first
      assign shifted = {sin, sr_q[WIDTH-1:1]};
      assign fresh   = {sin, {(WIDTH-1){1'b0}}};
    end
  endgenerate

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
    if (start) begin
      sr_d  = sin_valid ? fresh : '0;
      cnt_d = sin_valid ? CW'(1) : '0;
    end else if (sin_valid) begin
      sr_d = shifted;
      if (cnt_q == LAST_CNT) begin
        complete = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // A completed word is dropped only when the held word is neither empty nor
  // leaving on this same edge.
  assign consume = valid_q & dout_ready;
  assign drop    = complete & valid_q & ~dout_ready;

  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete && !drop) begin
      dout_d  = shifted;
      valid_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
    if (drop) begin
      ovr_d = 1'b1;
    end else if (clr_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_q    <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = ovr_q;
  assign bit_cnt    = cnt_q;

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Bench for sipo_word_assembler: MSB-first and LSB-first instances share one
// stimulus stream and are checked against a bit-queue reference model.
module tb_sipo_word_assembler;

  localparam int W  = 4;
  localparam int CW = $clog2(W);

  logic clk = 1'b0;
  logic rst, sin, sin_valid, start, dout_ready, clr_overrun;
  logic [W-1:0]  dout_m, dout_l;
  logic          valid_m, valid_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit        m_bits[$];
  logic [W-1:0] m_dout_m, m_dout_l;
  bit        m_valid, m_ovr;

  always #5 clk = ~clk;

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .start(start),
    .dout(dout_m), .dout_valid(valid_m), .dout_ready(dout_ready),
    .overrun(ovr_m), .clr_overrun(clr_overrun), .bit_cnt(cnt_m)
  );

  sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .start(start),
    .dout(dout_l), .dout_valid(valid_l), .dout_ready(dout_ready),
    .overrun(ovr_l), .clr_overrun(clr_overrun), .bit_cnt(cnt_l)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_bits.delete();
    m_dout_m = '0;
    m_dout_l = '0;
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
  endtask

  // One clock edge of the reference model, described in terms of the received
  // bit sequence rather than a shift register.
  task automatic model_step(input bit sv, input bit s, input bit st, input bit rdy, input bit clr);
    bit complete = 1'b0;
    bit drop = 1'b0;
    logic [W-1:0] wm = '0;
    logic [W-1:0] wl = '0;
    if (st) begin
      m_bits.delete();
      if (sv) m_bits.push_back(s);
    end else if (sv) begin
      m_bits.push_back(s);
      if (m_bits.size() == W) begin
        complete = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = m_bits[i];
          wl[i]     = m_bits[i];
        end
        m_bits.delete();
      end
    end
    if (complete) begin
      if (!m_valid || rdy) begin
        m_dout_m = wm;
        m_dout_l = wl;
        m_valid  = 1'b1;
        $display("word msb_first=%b lsb_first=%b loaded", wm, wl);
      end else begin
        drop = 1'b1;
        $display("word msb_first=%b dropped (held word not consumed)", wm);
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (drop) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_state();
    check_eq("bit_cnt_msb", 32'(cnt_m), 32'(m_bits.size()));
    check_eq("bit_cnt_lsb", 32'(cnt_l), 32'(m_bits.size()));
    check_eq("valid_msb", 32'(valid_m), 32'(m_valid));
    check_eq("valid_lsb", 32'(valid_l), 32'(m_valid));
    check_eq("dout_msb", 32'(dout_m), 32'(m_dout_m));
    check_eq("dout_lsb", 32'(dout_l), 32'(m_dout_l));
    check_eq("overrun_msb", 32'(ovr_m), 32'(m_ovr));
    check_eq("overrun_lsb", 32'(ovr_l), 32'(m_ovr));
  endtask

  // Called at a negedge: apply inputs, advance the model, wait past the
  // rising edge to the next negedge and compare.
  task automatic drive(input bit sv, input bit s, input bit st, input bit rdy, input bit clr);
    sin_valid   = sv;
    sin         = s;
    start       = st;
    dout_ready  = rdy;
    clr_overrun = clr;
    model_step(sv, s, st, rdy, clr);
    @(negedge clk);
    check_state();
  endtask

  task automatic send_bits(input logic [3:0] b, input bit rdy);
    for (int i = 3; i >= 0; i--) drive(1'b1, b[i], 1'b0, rdy, 1'b0);
  endtask

  // Asserts reset mid-cycle and checks the outputs clear before any edge.
  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_async_cnt", 32'(cnt_m), 32'd0);
    check_eq("rst_async_dout", 32'(dout_m), 32'd0);
    check_eq("rst_async_valid", 32'(valid_m), 32'd0);
    check_eq("rst_async_ovr", 32'(ovr_m), 32'd0);
    model_reset();
    sin_valid = 1'b0; start = 1'b0; clr_overrun = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_state();
  endtask

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; start = 1'b0;
    dout_ready = 1'b0; clr_overrun = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_state();

    // Basic word, both bit orders
    send_bits(4'b1011, 1'b1);
    check_eq("basic_dout_msb", 32'(dout_m), 32'h0b);
    check_eq("basic_dout_lsb", 32'(dout_l), 32'h0d);
    check_eq("basic_valid", 32'(valid_m), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("basic_valid_drop", 32'(valid_m), 32'd0);

    // Overrun with stalled consumer, then drain and clear
    send_bits(4'b1011, 1'b0);
    send_bits(4'b0110, 1'b0);
    check_eq("ovr_dout_held", 32'(dout_m), 32'h0b);
    check_eq("ovr_set", 32'(ovr_m), 32'd1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("ovr_drain_valid", 32'(valid_m), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("ovr_cleared", 32'(ovr_m), 32'd0);

    // Consume on the same edge as the next completion
    send_bits(4'b1011, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("simul_dout", 32'(dout_m), 32'h06);
    check_eq("simul_valid", 32'(valid_m), 32'd1);
    check_eq("simul_ovr", 32'(ovr_m), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Frame sync discards a partial word
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    check_eq("start_cnt", 32'(cnt_m), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_eq("start_dout", 32'(dout_m), 32'h0c);

    // Reset mid-word, then with a held word and overrun pending
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    async_reset();
    send_bits(4'b1111, 1'b0);
    send_bits(4'b1010, 1'b0);
    async_reset();
    send_bits(4'b0111, 1'b0);
    check_eq("post_rst_dout", 32'(dout_m), 32'h07);
    check_eq("post_rst_ovr", 32'(ovr_m), 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        async_reset();
      end else begin
        drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
              $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 7) == 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
